gb_timer: RTL and testbench

GB_TIMER -- requirements
Module: gb_timer

---
 rtl/gb_timer.sv | 139 +++++++++++++
 tb/tb_gb_timer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_timer.sv
// gb_timer: DIV/TIMA/TMA/TAC timer with a byte-wide register bus and a one-clock read latency.
// Define GB_TIMER_RELOAD_DELAY_EN to delay the TIMA reload and interrupt by 4 clocks after overflow.
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04,
    parameter int          DIV_W     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic [7:0]  data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        irq_timer
);

    typedef enum logic [1:0] {
        REG_DIV  = 2'd0,
        REG_TIMA = 2'd1,
        REG_TMA  = 2'd2,
        REG_TAC  = 2'd3
    } reg_sel_e;

    logic [DIV_W-1:0] counter, counter_next;
    logic [7:0]       tima, tima_next;
    logic [7:0]       tma, tma_next;
    logic [2:0]       tac, tac_next;
    logic             level_q, level_next, tap, fall;
    logic             irq_next;
    logic [15:0]      offset;
    logic             hit;
    reg_sel_e         sel;
    logic             wr_div, wr_tima, wr_tma, wr_tac;
    logic [7:0]       read_val;
`ifdef GB_TIMER_RELOAD_DELAY_EN
    logic [2:0]       reload_cnt, reload_cnt_next;
`endif

    assign offset  = addr - BASE_ADDR;
    assign hit     = (offset < 16'd4);
    assign sel     = reg_sel_e'(offset[1:0]);
    assign wr_div  = hit && wr && (sel == REG_DIV);
    assign wr_tima = hit && wr && (sel == REG_TIMA);
    assign wr_tma  = hit && wr && (sel == REG_TMA);
    assign wr_tac  = hit && wr && (sel == REG_TAC);

    // Reads sample the pre-edge register values, so a same-clock write returns the old value.
    always_comb begin
        case (sel)
            REG_DIV:  read_val = counter[DIV_W-1 -: 8];
            REG_TIMA: read_val = tima;
            REG_TMA:  read_val = tma;
            default:  read_val = {5'b11111, tac};
        endcase
    end

    // NOTE: every variable gets a value before any branch so no latch can be inferred.
    always_comb begin
        counter_next = wr_div ? '0 : counter + DIV_W'(1);
        tac_next     = wr_tac ? data_in[2:0] : tac;
        tma_next     = wr_tma ? data_in : tma;
        case (tac_next[1:0])
            2'b00:   tap = counter_next[9];
            2'b01:   tap = counter_next[3];
            2'b10:   tap = counter_next[5];
            default: tap = counter_next[7];
        endcase
        // NOTE: the level is judged on next-state values so a fall caused by a DIV or TAC write counts on that same edge.
        level_next = tap & tac_next[2];
        fall       = level_q & ~level_next;

        tima_next = tima;
        irq_next  = 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
        reload_cnt_next = reload_cnt;
        if (wr_tima) begin
            tima_next       = data_in;
            reload_cnt_next = 3'd0;
        end else if (reload_cnt != 3'd0) begin
            reload_cnt_next = reload_cnt - 3'd1;
            if (reload_cnt == 3'd1) begin
                tima_next = tma_next;
                irq_next  = 1'b1;
            end
        end else if (fall) begin
            if (tima == 8'hFF) begin
                tima_next       = 8'h00;
                reload_cnt_next = 3'd4;
            end else begin
                tima_next = tima + 8'd1;
            end
        end
`else
        if (wr_tima) begin
            tima_next = data_in;
        end else if (fall) begin
            if (tima == 8'hFF) begin
                tima_next = tma_next;
                irq_next  = 1'b1;
            end else begin
                tima_next = tima + 8'd1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter    <= '0;
            tima       <= 8'h00;
            tma        <= 8'h00;
            tac        <= 3'b000;
            level_q    <= 1'b0;
            irq_timer  <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
`ifdef GB_TIMER_RELOAD_DELAY_EN
            reload_cnt <= 3'd0;
`endif
        end else begin
            counter    <= counter_next;
            tima       <= tima_next;
            tma        <= tma_next;
            tac        <= tac_next;
            level_q    <= level_next;
            irq_timer  <= irq_next;
            data_valid <= hit && rd;
            if (hit && rd) begin
                data_out <= read_val;
            end
`ifdef GB_TIMER_RELOAD_DELAY_EN
            reload_cnt <= reload_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed and randomized bus traffic against a behavioural timer model.
// Honours GB_TIMER_RELOAD_DELAY_EN the same way as the design.
`timescale 1ns/1ps
module tb_gb_timer;

    localparam logic [15:0] BASE  = 16'hFF04;
    localparam int          DIV_W = 16;
    localparam int unsigned CNT_MASK = (32'd1 << DIV_W) - 32'd1;
`ifdef GB_TIMER_RELOAD_DELAY_EN
    localparam bit DLY = 1'b1;
`else
    localparam bit DLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic        rd;
    logic        wr;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        irq_timer;

    gb_timer #(.BASE_ADDR(BASE), .DIV_W(DIV_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (addr),
        .data_in    (data_in),
        .rd         (rd),
        .wr         (wr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .irq_timer  (irq_timer)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state: counter value, registers, last timer level, clocks left until reload.
    int unsigned m_cnt;
    int          m_tima, m_tma, m_tac, m_pend, m_dout;
    bit          m_prev, m_dv, m_irq;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic bit timer_level(input int unsigned cnt, input int tac);
        int bitpos;
        case (tac & 3)
            0:       bitpos = 9;
            1:       bitpos = 3;
            2:       bitpos = 5;
            default: bitpos = 7;
        endcase
        return ((tac & 4) != 0) && (((cnt >> bitpos) & 1) != 0);
    endfunction

    function automatic bit fall_next_idle();
        return m_prev && !timer_level((m_cnt + 1) & CNT_MASK, m_tac);
    endfunction

    function automatic bit reload_next();
        if (DLY) return m_pend == 1;
        return (m_tima == 255) && fall_next_idle();
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_pend = 0;
        m_dout = 0; m_prev = 0; m_dv = 0; m_irq = 0;
    endtask

    task automatic model_step(input logic [15:0] a, input int d, input bit r, input bit w);
        int unsigned off, n_cnt;
        int n_tac, n_tma, n_tima, n_pend, rdval;
        bit sel, lvl, fell, n_irq;
        off = (int'(a) - int'(BASE)) & 32'hFFFF;
        sel = off < 4;
        case (off)
            0:       rdval = (m_cnt >> (DIV_W - 8)) & 8'hFF;
            1:       rdval = m_tima;
            2:       rdval = m_tma;
            default: rdval = 8'hF8 | m_tac;
        endcase
        n_cnt = (sel && w && off == 0) ? 0 : (m_cnt + 1) & CNT_MASK;
        n_tac = (sel && w && off == 3) ? (d & 7) : m_tac;
        n_tma = (sel && w && off == 2) ? d : m_tma;
        lvl   = timer_level(n_cnt, n_tac);
        fell  = m_prev && !lvl;
        n_tima = m_tima;
        n_pend = m_pend;
        n_irq  = 0;
        if (sel && w && off == 1) begin
            n_tima = d;
            n_pend = 0;
        end else if (m_pend > 0) begin
            n_pend = m_pend - 1;
            if (n_pend == 0) begin
                n_tima = n_tma;
                n_irq  = 1;
            end
        end else if (fell) begin
            if (m_tima == 255) begin
                if (DLY) begin
                    n_tima = 0;
                    n_pend = 4;
                end else begin
                    n_tima = n_tma;
                    n_irq  = 1;
                end
            end else begin
                n_tima = m_tima + 1;
            end
        end
        if (sel && r) begin
            m_dout = rdval;
            m_dv   = 1;
        end else begin
            m_dv = 0;
        end
        m_cnt = n_cnt; m_tac = n_tac; m_tma = n_tma; m_tima = n_tima;
        m_pend = n_pend; m_irq = n_irq; m_prev = lvl;
    endtask

    // One bus clock: drive, step the model on the edge, compare outputs 1 ns later.
    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic r, input logic w);
        addr = a; data_in = d; rd = r; wr = w;
        @(posedge clk);
        if (reset_n) model_step(a, int'(d), r, w);
        #1;
        check("data_valid", data_valid, 8'(m_dv));
        check("irq_timer", irq_timer, 8'(m_irq));
        check("data_out", data_out, 8'(m_dout));
    endtask

    task automatic idle(input int n);
        repeat (n) bus(16'h0000, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
        bus(BASE + 16'(off), d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input logic [2:0] off);
        bus(BASE + 16'(off), 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  pulses, zeros;
        bit  found;
        logic [15:0] a;
        logic [7:0]  d;
        logic        r, w;
        int          kind;

        reset_n = 1'b0; addr = 16'h0; data_in = 8'h0; rd = 1'b0; wr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 8'h00);
        check("reset_irq", irq_timer, 8'h00);
        reset_n = 1'b1;

        // 256 quiet clocks, then DIV reads 0x01.
        idle(256);
        rd_reg(3'd0);
        check("div_after_256_valid", data_valid, 8'h01);
        check("div_after_256", data_out, 8'h01);

        // TAC readback pads with ones; the address past TMA+TAC is ignored.
        wr_reg(3'd3, 8'h07);
        rd_reg(3'd3);
        check("tac_read", data_out, 8'hFF);
        rd_reg(3'd4);
        check("unselected_valid", data_valid, 8'h00);
        check("unselected_hold", data_out, 8'hFF);

        // Fastest tap: 160 clocks after aligning the counter gives 10 increments.
        wr_reg(3'd3, 8'h05);
        wr_reg(3'd2, 8'h00);
        wr_reg(3'd0, 8'h00);
        wr_reg(3'd1, 8'h00);
        idle(159);
        rd_reg(3'd1);
        check("tima_160_clocks", data_out, 8'h0A);

        // Overflow from 0xFE with TMA 0x80, reading TIMA every clock.
        wr_reg(3'd2, 8'h80);
        wr_reg(3'd1, 8'hFE);
        pulses = 0; zeros = 0; found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            rd_reg(3'd1);
            if (data_out == 8'h00) zeros++;
            if (irq_timer) begin
                pulses++;
                found = 1'b1;
            end
        end
        check("overflow_irq_seen", 8'(pulses), 8'd1);
        check("overflow_zero_reads", 8'(zeros), 8'(DLY ? 4 : 0));
        rd_reg(3'd1);
        check("overflow_reload", data_out, 8'h80);
        check("overflow_single_pulse", irq_timer, 8'h00);

        // TMA written on the reload edge: the reload takes the new value.
        wr_reg(3'd1, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (reload_next()) found = 1'b1;
            else idle(1);
        end
        check("wait_reload_edge", 8'(found), 8'd1);
        wr_reg(3'd2, 8'h5A);
        check("tma_race_irq", irq_timer, 8'h01);
        rd_reg(3'd1);
        check("tma_race_tima", data_out, 8'h5A);

        // TIMA write on an increment edge wins.
        wr_reg(3'd1, 8'h10);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_pend == 0 && fall_next_idle()) found = 1'b1;
            else idle(1);
        end
        check("wait_increment_edge", 8'(found), 8'd1);
        wr_reg(3'd1, 8'h40);
        rd_reg(3'd1);
        check("tima_write_wins", data_out, 8'h40);

        // DIV write while tap bit 3 is high produces one increment and clears the counter.
        wr_reg(3'd0, 8'h00);
        wr_reg(3'd1, 8'h20);
        idle(7);
        wr_reg(3'd0, 8'hA5);
        rd_reg(3'd1);
        check("div_write_fall", data_out, 8'h21);
        rd_reg(3'd0);
        check("div_cleared", data_out, 8'h00);

`ifdef GB_TIMER_RELOAD_DELAY_EN
        // TIMA written on the second delay clock cancels reload and interrupt.
        wr_reg(3'd2, 8'h80);
        wr_reg(3'd1, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            idle(1);
            if (m_pend == 4) found = 1'b1;
        end
        check("wait_overflow", 8'(found), 8'd1);
        idle(1);
        wr_reg(3'd1, 8'h33);
        pulses = 0;
        repeat (8) begin
            idle(1);
            if (irq_timer) pulses++;
        end
        check("cancel_no_irq", 8'(pulses), 8'd0);
        rd_reg(3'd1);
        check("cancel_tima", data_out, 8'h33);
`endif

        // Randomized traffic, DIV writes kept rare so the timer makes progress.
        for (int i = 0; i < 3000; i++) begin
            kind = $urandom_range(0, 7);
            if (kind == 0)      a = BASE + 16'(4 + $urandom_range(0, 200));
            else if (kind == 1) a = BASE - 16'(1 + $urandom_range(0, 200));
            else                a = BASE + 16'($urandom_range(0, 3));
            r = ($urandom_range(0, 2) == 0);
            w = ($urandom_range(0, 5) == 0);
            if (w && a == BASE && $urandom_range(0, 9) != 0) w = 1'b0;
            d = 8'($urandom);
            bus(a, d, r, w);
        end

        // Asynchronous reset just before a reload: outputs clear at once, no pulse afterwards.
        wr_reg(3'd3, 8'h05);
        wr_reg(3'd2, 8'h77);
        wr_reg(3'd1, 8'hFF);
        rd_reg(3'd3);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (DLY ? (m_pend == 2) : reload_next()) found = 1'b1;
            else idle(1);
        end
        check("wait_reset_point", 8'(found), 8'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_data_out", data_out, 8'h00);
        check("async_reset_valid", data_valid, 8'h00);
        check("async_reset_irq", irq_timer, 8'h00);
        model_reset();
        addr = 16'h0; data_in = 8'h0; rd = 1'b0; wr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            idle(1);
            if (irq_timer) pulses++;
        end
        check("post_reset_no_irq", 8'(pulses), 8'd0);
        rd_reg(3'd1);
        check("post_reset_tima", data_out, 8'h00);
        rd_reg(3'd3);
        check("post_reset_tac", data_out, 8'hF8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
